// File: rtl/counter_scheduler.sv
// Round-robin owner of one shared interval counter: arbitrates requesters, counts
// 0..period for the winner, pulses done, then re-arbitrates from the next index.
module counter_scheduler #(
  parameter  int unsigned REQ_NUM   = 4,
  parameter  int unsigned MAX_VALUE = 255,
  localparam int unsigned WIDTH     = $clog2(MAX_VALUE + 1),
  localparam int unsigned IDX_W     = $clog2(REQ_NUM)
) (
  input  logic                       i_clk,
  input  logic                       i_s_rst,
  input  logic [REQ_NUM-1:0]         i_req,
  input  logic [REQ_NUM*WIDTH-1:0]   i_period,
  output logic [REQ_NUM-1:0]         o_grant,
  output logic [IDX_W-1:0]           o_idx,
  output logic                       o_busy,
  output logic [WIDTH-1:0]           o_value,
  output logic [REQ_NUM-1:0]         o_done
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_COUNT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [IDX_W-1:0]    rr_q, rr_d;
  logic [WIDTH-1:0]    period_q, period_d;
  logic [WIDTH-1:0]    count_q, count_d;
  logic [REQ_NUM-1:0]  grant_q, grant_d;
  logic [REQ_NUM-1:0]  done_q, done_d;
  logic                busy_q, busy_d;

  logic                win_found;
  logic [IDX_W-1:0]    win_idx;
  logic [WIDTH-1:0]    win_period;
  logic [WIDTH-1:0]    win_period_sat;

  // Index arithmetic modulo REQ_NUM (REQ_NUM need not be a power of two)
  function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] a,
                                                input int unsigned b);
    return IDX_W'((32'(a) + b) % REQ_NUM);
  endfunction

  // First asserted request at or after the rr pointer
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int unsigned k = 0; k < REQ_NUM; k++) begin
      if (!win_found && i_req[wrap_add(rr_q, k)]) begin
        win_found = 1'b1;
        win_idx   = wrap_add(rr_q, k);
      end
    end
  end

  assign win_period     = i_period[32'(win_idx)*WIDTH +: WIDTH];
  assign win_period_sat = ({1'b0, win_period} > (WIDTH+1)'(MAX_VALUE)) ?
                          WIDTH'(MAX_VALUE) : win_period;

  // Next-state and next-output logic
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    rr_d     = rr_q;
    period_d = period_q;
    count_d  = count_q;
    grant_d  = '0;
    done_d   = '0;
    busy_d   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (win_found) begin
          state_d  = ST_COUNT;
          idx_d    = win_idx;
          period_d = win_period_sat;
          count_d  = '0;
          grant_d  = REQ_NUM'(1) << win_idx;
          busy_d   = 1'b1;
        end
      end
      ST_COUNT: begin
        if (!i_req[idx_q]) begin
          // Owner withdrew: release without a done pulse
          state_d = ST_IDLE;
          rr_d    = wrap_add(idx_q, 1);
        end else if (count_q == period_q) begin
          state_d        = ST_DONE;
          done_d[idx_q]  = 1'b1;
        end else begin
          count_d = count_q + WIDTH'(1);
          grant_d = REQ_NUM'(1) << idx_q;
          busy_d  = 1'b1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        rr_d    = wrap_add(idx_q, 1);
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_s_rst) begin
      state_q  <= ST_IDLE;
      idx_q    <= '0;
      rr_q     <= '0;
      period_q <= '0;
      count_q  <= '0;
      grant_q  <= '0;
      done_q   <= '0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      rr_q     <= rr_d;
      period_q <= period_d;
      count_q  <= count_d;
      grant_q  <= grant_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
    end
  end

  assign o_grant = grant_q;
  assign o_idx   = idx_q;
  assign o_busy  = busy_q;
  assign o_value = count_q;
  assign o_done  = done_q;

endmodule

// File: tb/tb_counter_scheduler.sv
// Self-checking bench for counter_scheduler: directed scenarios plus randomized
// transactions compared against a transaction-level round-robin model.
module tb_counter_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [31:0] per;
  logic [3:0]  o_grant;
  logic [1:0]  o_idx;
  logic        o_busy;
  logic [7:0]  o_value;
  logic [3:0]  o_done;

  // Small instance whose period field can exceed MAX_VALUE
  logic [1:0]  s_req;
  logic [7:0]  s_per;
  logic [1:0]  s_grant;
  logic        s_idx;
  logic        s_busy;
  logic [3:0]  s_value;
  logic [1:0]  s_done;

  int checks   = 0;
  int failures = 0;
  int m_rr     = 0;

  always #5 clk = ~clk;

  counter_scheduler #(.REQ_NUM(4), .MAX_VALUE(255)) u_dut (
    .i_clk(clk), .i_s_rst(rst), .i_req(req), .i_period(per),
    .o_grant(o_grant), .o_idx(o_idx), .o_busy(o_busy),
    .o_value(o_value), .o_done(o_done)
  );

  counter_scheduler #(.REQ_NUM(2), .MAX_VALUE(10)) u_sat (
    .i_clk(clk), .i_s_rst(rst), .i_req(s_req), .i_period(s_per),
    .o_grant(s_grant), .o_idx(s_idx), .o_busy(s_busy),
    .o_value(s_value), .o_done(s_done)
  );

  // Reference arbitration: first requester at or after the pointer, wrapping
  function automatic int model_pick(input logic [3:0] r, input int rr);
    for (int k = 0; k < 4; k++)
      if (r[(rr + k) % 4]) return (rr + k) % 4;
    return -1;
  endfunction

  // Observes one grant from request to return-to-idle; records a summary only
  task automatic capture(input int maxc, input bit rel,
                         output int lat, output int gidx, output int blen,
                         output int last, output bit seq_ok, output int didx,
                         output int dlen, output int dat, output bit clean,
                         output bit ended);
    lat = 0; gidx = -1; blen = 0; last = -1; seq_ok = 1'b1; didx = -1;
    dlen = 0; dat = -1; clean = 1'b1; ended = 1'b0;
    for (int c = 0; c < maxc && !ended; c++) begin
      @(negedge clk);
      if (o_busy) begin
        if (blen == 0) begin lat = c + 1; gidx = int'(o_idx); end
        if (o_grant !== (4'b0001 << gidx) || int'(o_idx) != gidx) clean = 1'b0;
        if (o_value !== 8'(blen)) seq_ok = 1'b0;
        if (o_done !== 4'b0000) clean = 1'b0;
        last = int'(o_value);
        blen++;
      end else if (o_done !== 4'b0000) begin
        if (o_grant !== 4'b0000 || $countones(o_done) != 1) clean = 1'b0;
        for (int k = 0; k < 4; k++) if (o_done[k]) didx = k;
        dlen++;
        dat = c + 1;
        if (rel && didx >= 0) req[didx] = 1'b0;
      end else if (blen > 0) begin
        ended = 1'b1;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; req = '0; per = '0; s_req = '0; s_per = '0;
    repeat (3) @(negedge clk);
    checks++;
    if ({o_grant, o_done, o_busy, o_value, o_idx} !== 19'd0) begin
      failures++;
      $display("FAIL reset_outputs: grant=%b done=%b busy=%b value=%0d idx=%0d, want all 0",
               o_grant, o_done, o_busy, o_value, o_idx);
    end
    checks++;
    if ({s_grant, s_done, s_busy, s_value, s_idx} !== 10'd0) begin
      failures++;
      $display("FAIL reset_sat_outputs: grant=%b done=%b busy=%b value=%0d, want all 0",
               s_grant, s_done, s_busy, s_value);
    end
    rst = 1'b0; m_rr = 0;
  endtask

  task automatic test_single();
    int lat, gidx, blen, last, didx, dlen, dat;
    bit seq_ok, clean, ended;
    per[7:0] = 8'd3; req = 4'b0001;
    capture(30, 1'b1, lat, gidx, blen, last, seq_ok, didx, dlen, dat, clean, ended);
    checks++;
    if (lat != 1 || gidx != 0) begin
      failures++;
      $display("FAIL single_grant: latency=%0d idx=%0d, want 1 and 0", lat, gidx);
    end
    checks++;
    if (blen != 4 || last != 3 || !seq_ok) begin
      failures++;
      $display("FAIL single_count: cycles=%0d last=%0d seq_ok=%0b, want 4, 3, 1", blen, last, seq_ok);
    end
    checks++;
    if (didx != 0 || dlen != 1 || dat != 5 || !clean || !ended) begin
      failures++;
      $display("FAIL single_done: idx=%0d len=%0d at=%0d clean=%0b ended=%0b, want 0,1,5,1,1",
               didx, dlen, dat, clean, ended);
    end
    m_rr = 1;
  endtask

  task automatic test_round_robin();
    int lat, gidx, blen, last, didx, dlen, dat, exp;
    bit seq_ok, clean, ended;
    rst = 1'b1; @(negedge clk); @(negedge clk); rst = 1'b0; m_rr = 0;
    per = {8'd1, 8'd1, 8'd1, 8'd1}; req = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      exp = model_pick(req, m_rr);
      capture(20, 1'b0, lat, gidx, blen, last, seq_ok, didx, dlen, dat, clean, ended);
      checks++;
      if (gidx != exp || didx != exp || blen != 2 || dlen != 1 || !clean || !ended || lat != 1) begin
        failures++;
        $display("FAIL rr_grant%0d: idx=%0d done_idx=%0d cycles=%0d done_len=%0d clean=%0b lat=%0d, want idx %0d, 2 cycles, 1 pulse",
                 g, gidx, didx, blen, dlen, clean, lat, exp);
      end
      m_rr = (exp + 1) % 4;
    end
    req = '0;
    @(negedge clk);
  endtask

  task automatic test_period_edges();
    int lat, gidx, blen, last, didx, dlen, dat, sblen, slast;
    bit seq_ok, clean, ended, sended;
    logic [1:0] sd;
    per[7:0] = 8'd0; req = 4'b0001;
    capture(20, 1'b1, lat, gidx, blen, last, seq_ok, didx, dlen, dat, clean, ended);
    checks++;
    if (gidx != 0 || blen != 1 || last != 0 || didx != 0 || dat != 2 || dlen != 1) begin
      failures++;
      $display("FAIL period_zero: idx=%0d cycles=%0d last=%0d done_idx=%0d at=%0d, want 0,1,0,0,2",
               gidx, blen, last, didx, dat);
    end
    m_rr = 1;
    per[15:8] = 8'd255; req = 4'b0010;
    capture(300, 1'b1, lat, gidx, blen, last, seq_ok, didx, dlen, dat, clean, ended);
    checks++;
    if (gidx != 1 || blen != 256 || last != 255 || !seq_ok || didx != 1 || !clean) begin
      failures++;
      $display("FAIL period_max: idx=%0d cycles=%0d last=%0d seq_ok=%0b done_idx=%0d, want 1,256,255,1,1",
               gidx, blen, last, seq_ok, didx);
    end
    m_rr = 2;
    // Period 15 on a MAX_VALUE=10 instance must saturate to 10
    s_per = {4'd15, 4'd3}; s_req = 2'b10;
    sblen = 0; slast = -1; sd = '0; sended = 1'b0;
    for (int c = 0; c < 40 && !sended; c++) begin
      @(negedge clk);
      if (s_busy) begin sblen++; slast = int'(s_value); end
      if (s_done !== 2'b00) begin sd = s_done; s_req = 2'b00; end
      else if (sblen > 0 && !s_busy) sended = 1'b1;
    end
    checks++;
    if (sblen != 11 || slast != 10 || sd !== 2'b10 || !sended) begin
      failures++;
      $display("FAIL period_saturate: cycles=%0d last=%0d done=%b, want 11, 10, 10", sblen, slast, sd);
    end
  endtask

  task automatic test_abort();
    int lat, gidx, blen, last, didx, dlen, dat, exp;
    bit seq_ok, clean, ended, hit, bad_done, bad_owner;
    per[23:16] = 8'd10; per[31:24] = 8'd5; req = 4'b0100;
    hit = 1'b0; bad_done = 1'b0; bad_owner = 1'b0;
    for (int c = 0; c < 30 && !hit; c++) begin
      @(negedge clk);
      if (o_done !== 4'b0000) bad_done = 1'b1;
      if (o_busy && o_value == 8'd3 && o_grant !== 4'b0100) bad_owner = 1'b1;
      if (o_busy && o_value == 8'd2) req[3] = 1'b1;
      if (o_busy && o_value == 8'd5) begin req[2] = 1'b0; hit = 1'b1; end
    end
    checks++;
    if (!hit || bad_owner) begin
      failures++;
      $display("FAIL abort_reach: reached=%0b owner_changed=%0b, want 1 and 0", hit, bad_owner);
    end
    @(negedge clk);
    checks++;
    if (o_busy !== 1'b0 || o_grant !== 4'b0000 || o_done !== 4'b0000 || bad_done) begin
      failures++;
      $display("FAIL abort_idle: busy=%b grant=%b done=%b early_done=%0b, want 0,0000,0000,0",
               o_busy, o_grant, o_done, bad_done);
    end
    m_rr = 3;
    exp = model_pick(req, m_rr);
    capture(30, 1'b1, lat, gidx, blen, last, seq_ok, didx, dlen, dat, clean, ended);
    checks++;
    if (gidx != exp || lat != 1 || blen != 6 || didx != exp || !clean) begin
      failures++;
      $display("FAIL abort_next: idx=%0d lat=%0d cycles=%0d done_idx=%0d, want idx %0d, lat 1, 6 cycles",
               gidx, lat, blen, didx, exp);
    end
    m_rr = (exp + 1) % 4;
    req = '0;
  endtask

  task automatic test_latch();
    int last, didx;
    bit ended, seen;
    per[15:8] = 8'd4; req = 4'b0010;
    last = -1; didx = -1; ended = 1'b0; seen = 1'b0;
    for (int c = 0; c < 40 && !ended; c++) begin
      @(negedge clk);
      if (o_busy) begin
        seen = 1'b1; last = int'(o_value);
        if (o_value == 8'd1) per[15:8] = 8'd9;
      end else if (o_done !== 4'b0000) begin
        for (int k = 0; k < 4; k++) if (o_done[k]) didx = k;
        req = '0;
      end else if (seen) ended = 1'b1;
    end
    checks++;
    if (last != 4 || didx != 1 || !ended) begin
      failures++;
      $display("FAIL period_latched: last=%0d done_idx=%0d ended=%0b, want 4, 1, 1", last, didx, ended);
    end
    m_rr = 2;
  endtask

  task automatic test_random();
    int lat, gidx, blen, last, didx, dlen, dat, exp, expp;
    bit seq_ok, clean, ended;
    logic [3:0] r;
    for (int t = 0; t < 25; t++) begin
      r = 4'($urandom_range(1, 15));
      for (int k = 0; k < 4; k++) per[k*8 +: 8] = 8'($urandom_range(0, 12));
      req = r;
      exp = model_pick(r, m_rr);
      expp = int'(per[exp*8 +: 8]);
      capture(40, 1'b1, lat, gidx, blen, last, seq_ok, didx, dlen, dat, clean, ended);
      checks++;
      if (gidx != exp || didx != exp) begin
        failures++;
        $display("FAIL rand%0d_owner: req=%b idx=%0d done_idx=%0d, want %0d", t, r, gidx, didx, exp);
      end
      checks++;
      if (blen != expp + 1 || last != expp || !seq_ok) begin
        failures++;
        $display("FAIL rand%0d_count: cycles=%0d last=%0d seq_ok=%0b, want %0d cycles ending at %0d",
                 t, blen, last, seq_ok, expp + 1, expp);
      end
      checks++;
      if (lat != 1 || dlen != 1 || dat != expp + 2 || !clean || !ended) begin
        failures++;
        $display("FAIL rand%0d_timing: lat=%0d done_len=%0d done_at=%0d clean=%0b, want 1,1,%0d,1",
                 t, lat, dlen, dat, clean, expp + 2);
      end
      m_rr = (exp + 1) % 4;
    end
    req = '0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int lat, gidx, blen, last, didx, dlen, dat;
    bit seq_ok, clean, ended, hit;
    per[7:0] = 8'd20; req = 4'b0001; hit = 1'b0;
    for (int c = 0; c < 40 && !hit; c++) begin
      @(negedge clk);
      if (o_busy && o_value == 8'd7) begin rst = 1'b1; hit = 1'b1; end
    end
    @(negedge clk);
    checks++;
    if (!hit || {o_grant, o_done, o_busy, o_value, o_idx} !== 19'd0) begin
      failures++;
      $display("FAIL reset_mid: reached=%0b grant=%b done=%b busy=%b value=%0d idx=%0d, want all 0",
               hit, o_grant, o_done, o_busy, o_value, o_idx);
    end
    rst = 1'b0; m_rr = 0;
    per[15:8] = 8'd2; per[23:16] = 8'd2; req = 4'b0110;
    capture(30, 1'b1, lat, gidx, blen, last, seq_ok, didx, dlen, dat, clean, ended);
    checks++;
    if (gidx != model_pick(4'b0110, 0) || lat != 1 || blen != 3 || didx != gidx) begin
      failures++;
      $display("FAIL reset_pointer: idx=%0d lat=%0d cycles=%0d done_idx=%0d, want idx 1, lat 1, 3 cycles",
               gidx, lat, blen, didx);
    end
    req = '0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_period_edges();
    test_abort();
    test_latch();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
